// File: rtl/vector_stepper.sv
// Vector display beam stepper: accepts DRAW/MOVE/EOF/NOP command words and walks
// the X/Y DAC codes along Bresenham lines, with a post-command settle dwell.
module vector_stepper #(
  parameter int DAC_WIDTH    = 8,
  parameter int CEASE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2*DAC_WIDTH+1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DAC_WIDTH-1:0]     x_out,
  output logic [DAC_WIDTH-1:0]     y_out,
  output logic                     beam_on,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int DATAWIDTH = 2*DAC_WIDTH+2;
  localparam int EW        = DAC_WIDTH+2;
  localparam int CW        = (CEASE_CYCLES > 1) ? $clog2(CEASE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = (CEASE_CYCLES > 0) ? CW'(CEASE_CYCLES-1) : '0;
  localparam logic HAS_SETTLE = (CEASE_CYCLES > 0);

  localparam logic [1:0] CMD_DRAW = 2'd0;
  localparam logic [1:0] CMD_MOVE = 2'd1;
  localparam logic [1:0] CMD_EOF  = 2'd2;
  localparam logic [1:0] CMD_NOP  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, SETTLE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [1:0]            cmd;
  logic [DAC_WIDTH-1:0]  tgt_x, tgt_y;
  logic                  accept;

  logic [DAC_WIDTH-1:0]  tx_q, ty_q;
  logic [DAC_WIDTH-1:0]  dx_q, dy_q;
  logic                  sx_neg, sy_neg;
  logic signed [EW-1:0]  err_q;
  logic [CW-1:0]         settle_cnt;

  logic [DAC_WIDTH-1:0]  dx_new, dy_new;
  logic signed [EW-1:0]  err_new;

  logic signed [EW:0]    e2, dx_ext, dy_ext, sub_term, add_term, err_wide;
  logic                  move_x, move_y, reach;
  logic [DAC_WIDTH-1:0]  x_step, y_step;
  logic signed [EW-1:0]  err_step;

  assign cmd    = in_data[DATAWIDTH-1 -: 2];
  assign tgt_x  = in_data[2*DAC_WIDTH-1 -: DAC_WIDTH];
  assign tgt_y  = in_data[DAC_WIDTH-1:0];

  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // Line setup for a freshly accepted DRAW, relative to the current beam position
  always_comb begin
    dx_new  = (tgt_x >= x_out) ? (tgt_x - x_out) : (x_out - tgt_x);
    dy_new  = (tgt_y >= y_out) ? (tgt_y - y_out) : (y_out - tgt_y);
    err_new = $signed({2'b00, dx_new}) - $signed({2'b00, dy_new});
  end

  // One Bresenham step; the major axis always advances, so the target is hit exactly
  always_comb begin
    e2       = {err_q, 1'b0};
    dx_ext   = $signed({3'b000, dx_q});
    dy_ext   = $signed({3'b000, dy_q});
    move_x   = (e2 > -dy_ext);
    move_y   = (e2 < dx_ext);
    sub_term = move_x ? dy_ext : '0;
    add_term = move_y ? dx_ext : '0;
    err_wide = {err_q[EW-1], err_q} - sub_term + add_term;
    err_step = err_wide[EW-1:0];
    x_step   = x_out;
    y_step   = y_out;
    if (move_x) x_step = sx_neg ? (x_out - 1'b1) : (x_out + 1'b1);
    if (move_y) y_step = sy_neg ? (y_out - 1'b1) : (y_out + 1'b1);
    reach    = (x_step == tx_q) && (y_step == ty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && cmd == CMD_DRAW)      state_nxt = DRAW;
        else if (accept && cmd == CMD_MOVE) state_nxt = HAS_SETTLE ? SETTLE : IDLE;
      end
      DRAW: begin
        if (reach) state_nxt = HAS_SETTLE ? SETTLE : IDLE;
      end
      SETTLE: begin
        if (settle_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beam position, line parameters and the beam/frame outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out      <= '0;
      y_out      <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      sx_neg     <= 1'b0;
      sy_neg     <= 1'b0;
      err_q      <= '0;
      settle_cnt <= '0;
      beam_on    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          beam_on <= 1'b0;
          if (accept) begin
            case (cmd)
              CMD_DRAW: begin
                tx_q    <= tgt_x;
                ty_q    <= tgt_y;
                dx_q    <= dx_new;
                dy_q    <= dy_new;
                sx_neg  <= (tgt_x < x_out);
                sy_neg  <= (tgt_y < y_out);
                err_q   <= err_new;
                beam_on <= 1'b1;
              end
              CMD_MOVE: begin
                x_out      <= tgt_x;
                y_out      <= tgt_y;
                settle_cnt <= SETTLE_LOAD;
              end
              CMD_EOF:  frame_done <= 1'b1;
              CMD_NOP:  ;
              default:  ;
            endcase
          end
        end
        DRAW: begin
          x_out <= x_step;
          y_out <= y_step;
          err_q <= err_step;
          if (reach) begin
            settle_cnt <= SETTLE_LOAD;
            beam_on    <= HAS_SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) beam_on <= 1'b0;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        default: beam_on <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_stepper.sv
// Self-checking bench for vector_stepper: directed and random command words compared
// cycle by cycle against a line-drawing reference model built from integer arithmetic.
module tb_vector_stepper;

  localparam int W  = 8;
  localparam int C  = 2;
  localparam int DW = 2*W+2;

  localparam logic [1:0] C_DRAW = 2'd0;
  localparam logic [1:0] C_MOVE = 2'd1;
  localparam logic [1:0] C_EOF  = 2'd2;
  localparam logic [1:0] C_NOP  = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x_out, y_out;
  logic          beam_on, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int mx = 0;
  int my = 0;

  vector_stepper #(.DAC_WIDTH(W), .CEASE_CYCLES(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_out      (x_out),
    .y_out      (y_out),
    .beam_on    (beam_on),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int ex, input int ey,
                              input logic eb, input logic ebusy, input logic erdy, input logic efd);
    logic [2*W+3:0] obs, exp_v;
    obs   = {x_out, y_out, beam_on, busy, in_ready, frame_done};
    exp_v = {W'(ex), W'(ey), eb, ebusy, erdy, efd};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed x=%0d y=%0d beam=%b busy=%b ready=%b fd=%b, expected x=%0d y=%0d beam=%b busy=%b ready=%b fd=%b",
             tag, x_out, y_out, beam_on, busy, in_ready, frame_done, ex, ey, eb, ebusy, erdy, efd);
    end
  endtask

  // Presents one word from an idle negedge and checks every cycle until idle again
  task automatic apply_stimulus(input logic [1:0] cmd, input int tx, input int ty);
    int dx, dy, sx, sy, err, e2, cx, cy, len;
    int px[$];
    int py[$];
    check_output("pre_accept", mx, my, 1'b0, 1'b0, 1'b1, 1'b0);
    in_data  = {cmd, W'(tx), W'(ty)};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    case (cmd)
      C_DRAW: begin
        dx  = (tx > mx) ? tx - mx : mx - tx;
        dy  = (ty > my) ? ty - my : my - ty;
        sx  = (tx >= mx) ? 1 : -1;
        sy  = (ty >= my) ? 1 : -1;
        len = (dx > dy) ? dx : dy;
        if (len == 0) len = 1;
        cx  = mx;
        cy  = my;
        err = dx - dy;
        for (int i = 0; i < len; i++) begin
          e2 = 2 * err;
          if (e2 > -dy) begin err -= dy; cx += sx; end
          if (e2 < dx)  begin err += dx; cy += sy; end
          px.push_back(cx);
          py.push_back(cy);
        end
        for (int k = 0; k <= len + C; k++) begin
          @(negedge clk);
          if (k == 0)            check_output("draw_start", mx, my, 1'b1, 1'b1, 1'b0, 1'b0);
          else if (k < len)      check_output("draw_path", px[k-1], py[k-1], 1'b1, 1'b1, 1'b0, 1'b0);
          else if (k < len + C)  check_output("draw_dwell", tx, ty, 1'b1, 1'b1, 1'b0, 1'b0);
          else                   check_output("draw_done", tx, ty, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        mx = tx;
        my = ty;
      end
      C_MOVE: begin
        for (int k = 0; k <= C; k++) begin
          @(negedge clk);
          if (k < C) check_output("move_settle", tx, ty, 1'b0, 1'b1, 1'b0, 1'b0);
          else       check_output("move_done", tx, ty, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        mx = tx;
        my = ty;
      end
      C_EOF: begin
        @(negedge clk);
        check_output("eof_pulse", mx, my, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_output("eof_clear", mx, my, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      default: begin
        @(negedge clk);
        check_output("nop", mx, my, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    endcase
  endtask

  initial begin
    logic [1:0] rc;
    int rx, ry;

    $display("[TB] reset with in_valid held high");
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = {C_DRAW, 8'd50, 8'd60};
    repeat (3) begin
      @(negedge clk);
      check_output("reset_hold", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check_output("reset_release", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_output("post_reset_idle", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] directed lines");
    apply_stimulus(C_DRAW, 4, 2);
    apply_stimulus(C_MOVE, 255, 255);
    apply_stimulus(C_DRAW, 0, 255);
    apply_stimulus(C_DRAW, 0, 255);
    apply_stimulus(C_EOF, 0, 0);
    apply_stimulus(C_NOP, 0, 0);
    apply_stimulus(C_DRAW, 255, 0);

    $display("[TB] back-to-back words with in_valid held");
    check_output("b2b_pre", mx, my, 1'b0, 1'b0, 1'b1, 1'b0);
    in_data  = {C_DRAW, 8'd245, 8'd3};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = {C_MOVE, 8'd100, 8'd200};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      assert (in_ready === 1'b0 && busy === 1'b1) else begin
        errors++;
        $error("[TB] FAIL b2b_busy cycle %0d: observed ready=%b busy=%b, expected ready=0 busy=1", k, in_ready, busy);
      end
    end
    @(negedge clk);
    check_output("b2b_ready", 245, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("b2b_second", 100, 200, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_output("b2b_settle", 100, 200, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_output("b2b_idle", 100, 200, 1'b0, 1'b0, 1'b1, 1'b0);
    mx = 100;
    my = 200;

    $display("[TB] random command words");
    repeat (24) begin
      rc = 2'($urandom_range(0, 3));
      rx = int'($urandom_range(0, 255));
      ry = int'($urandom_range(0, 255));
      apply_stimulus(rc, rx, ry);
    end

    $display("[TB] reset pulsed mid-line");
    in_data  = {C_DRAW, ((mx < 128) ? 8'd255 : 8'd0), W'(my)};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("mid_reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("mid_reset_release", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_output("no_resume", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    mx = 0;
    my = 0;
    apply_stimulus(C_DRAW, 3, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
